decimal_key_debounce: RTL and testbench

Debounces and qualifies ten raw decimal key lines (keys 0-9) and emits a single-cycle, one-hot key event. Its one-hot output drives the 10-bit one-hot input of the BCD encoder directly. The encoder output is qualified by this block's `key_valid` strobe. The strobe is required because the encoder maps key 0 and "no key" to the same BCD code 0000.

---
 rtl/decimal_key_debounce_if.sv | 25 ++
 rtl/decimal_key_debounce.sv | 140 ++++++++++++++
 tb/tb_decimal_key_debounce.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/decimal_key_debounce_if.sv
// Key pad bundle: raw key lines in, one-hot key event and status out.
// master drives the raw lines, slave is the debouncer.
interface decimal_key_debounce_if;
  logic [9:0] keys_raw;
  logic [9:0] key_onehot;
  logic       key_valid;
  logic       key_held;
  logic       multi_err;

  modport master (
    output keys_raw,
    input  key_onehot,
    input  key_valid,
    input  key_held,
    input  multi_err
  );

  modport slave (
    input  keys_raw,
    output key_onehot,
    output key_valid,
    output key_held,
    output multi_err
  );
endinterface

// File: rtl/decimal_key_debounce.sv
// Debounces ten decimal key lines into a one-cycle one-hot key event.
// A key must be debounced as released before another press is taken.
module decimal_key_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input logic                   clk,
  input logic                   rst,
  decimal_key_debounce_if.slave kb
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CONE = CW'(1);
  localparam bit FAST = (DEBOUNCE_CYCLES == 1);

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    PRESSED,
    RELEASE
  } state_t;

  state_t        st;
  state_t        st_nx;
  logic [9:0]    sync1;
  logic [9:0]    s;
  logic [9:0]    cap;
  logic [9:0]    cap_nx;
  logic [9:0]    oh_q;
  logic          vld_q;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic [CW-1:0] cnt_inc;
  logic          emit;
  logic          one_hot;
  logic          multi;
  logic          held;
  logic          merr;

  // s & (s-1) clears the lowest set bit: non-zero means 2+ keys.
  assign multi   = (s & (s - 10'd1)) != 10'd0;
  assign one_hot = (s != 10'd0) && !multi;
  assign cnt_inc = (cnt == CMAX) ? cnt : cnt + CONE;

  // Two-flop synchronizer for the asynchronous key lines.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      s     <= '0;
    end else begin
      sync1 <= kb.keys_raw;
      s     <= sync1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) st <= IDLE;
    else     st <= st_nx;
  end

  // Next state, capture/counter updates and event decision.
  always_comb begin
    st_nx  = st;
    cap_nx = cap;
    cnt_nx = cnt;
    emit   = 1'b0;
    unique case (st)
      IDLE: begin
        if (one_hot) begin
          cap_nx = s;
          cnt_nx = CONE;
          if (FAST) begin
            emit  = 1'b1;
            st_nx = PRESSED;
          end else begin
            st_nx = DEBOUNCE;
          end
        end
      end
      DEBOUNCE: begin
        if (s == cap) begin
          cnt_nx = cnt_inc;
          if (cnt_inc == CMAX) begin
            emit  = 1'b1;
            st_nx = PRESSED;
          end
        end else begin
          st_nx = IDLE;
        end
      end
      PRESSED: begin
        if (s == 10'd0) begin
          cnt_nx = CONE;
          st_nx  = FAST ? IDLE : RELEASE;
        end
      end
      RELEASE: begin
        if (s == 10'd0) begin
          cnt_nx = cnt_inc;
          if (cnt_inc == CMAX) st_nx = IDLE;
        end else begin
          st_nx = PRESSED;
        end
      end
      default: st_nx = IDLE;
    endcase
  end

  // Capture, counter and the registered one-cycle event strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap   <= '0;
      cnt   <= '0;
      oh_q  <= '0;
      vld_q <= 1'b0;
    end else begin
      cap   <= cap_nx;
      cnt   <= cnt_nx;
      oh_q  <= emit ? cap_nx : 10'd0;
      vld_q <= emit;
    end
  end

  // Status outputs, forced low while reset is asserted.
  always_comb begin
    held = 1'b0;
    merr = 1'b0;
    if (!rst) begin
      held = (st == PRESSED) || (st == RELEASE);
      merr = (st == IDLE) && multi;
    end
  end

  assign kb.key_onehot = oh_q;
  assign kb.key_valid  = vld_q;
  assign kb.key_held   = held;
  assign kb.multi_err  = merr;

endmodule

// File: tb/tb_decimal_key_debounce.sv
// Bench for decimal_key_debounce: directed timing cases plus random
// key traffic against a run-length key model, for D=4 and D=1.
module tb_decimal_key_debounce;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  decimal_key_debounce_if kb0 ();
  decimal_key_debounce_if kb1 ();

  decimal_key_debounce #(.DEBOUNCE_CYCLES(4)) dut0 (
    .clk (clk),
    .rst (rst),
    .kb  (kb0)
  );

  decimal_key_debounce #(.DEBOUNCE_CYCLES(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .kb  (kb1)
  );

  logic [9:0] d_oh [2];
  logic       d_vld [2];
  logic       d_hld [2];
  logic       d_mer [2];

  assign d_oh[0]  = kb0.key_onehot;
  assign d_vld[0] = kb0.key_valid;
  assign d_hld[0] = kb0.key_held;
  assign d_mer[0] = kb0.multi_err;
  assign d_oh[1]  = kb1.key_onehot;
  assign d_vld[1] = kb1.key_valid;
  assign d_hld[1] = kb1.key_held;
  assign d_mer[1] = kb1.multi_err;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Reference model: s is raw delayed two samples; a press is a
  // one-hot value seen for D consecutive samples starting from rest,
  // a release is D consecutive zero samples while a key is held.
  logic [9:0] m_s1 [2] = '{default: '0};
  logic [9:0] m_s  [2] = '{default: '0};
  logic [9:0] m_cand [2] = '{default: '0};
  bit         m_held [2] = '{default: 0};
  bit         m_ev   [2] = '{default: 0};
  int         m_run  [2] = '{default: 0};
  int         m_rel  [2] = '{default: 0};
  int         m_d    [2] = '{4, 1};

  task automatic mstep(input int i, input logic r, input logic [9:0] raw);
    m_ev[i] = 0;
    if (r) begin
      m_s1[i] = '0;
      m_s[i] = '0;
      m_cand[i] = '0;
      m_held[i] = 0;
      m_run[i] = 0;
      m_rel[i] = 0;
    end else begin
      if (!m_held[i]) begin
        if (m_run[i] == 0) begin
          if ($countones(m_s[i]) == 1) begin
            m_cand[i] = m_s[i];
            m_run[i] = 1;
          end
        end else if (m_s[i] == m_cand[i]) begin
          m_run[i]++;
        end else begin
          m_run[i] = 0;
        end
        if (m_run[i] >= m_d[i]) begin
          m_ev[i] = 1;
          m_held[i] = 1;
          m_run[i] = 0;
          m_rel[i] = 0;
        end
      end else begin
        if (m_s[i] == 10'd0) m_rel[i]++;
        else m_rel[i] = 0;
        if (m_rel[i] >= m_d[i]) begin
          m_held[i] = 0;
          m_rel[i] = 0;
        end
      end
      m_s[i] = m_s1[i];
      m_s1[i] = raw;
    end
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    mstep(0, rst, kb0.keys_raw);
    mstep(1, rst, kb1.keys_raw);
  end

  // Per-cycle compare plus pulse / release bookkeeping.
  int         pcnt [2] = '{default: 0};
  int         pcyc [2] = '{default: 0};
  logic [9:0] pval [2] = '{default: '0};
  int         fcyc [2] = '{default: 0};
  logic       phld [2] = '{default: 1'b0};

  always @(negedge clk) begin
    if (cyc > 0) begin
      for (int i = 0; i < 2; i++) begin
        logic [9:0] e_oh;
        logic       e_idle;
        e_oh = m_ev[i] ? m_cand[i] : 10'd0;
        e_idle = !m_held[i] && (m_run[i] == 0);
        chk($sformatf("m%0d_valid", i), 32'(d_vld[i]), 32'(m_ev[i]));
        chk($sformatf("m%0d_onehot", i), 32'(d_oh[i]), 32'(e_oh));
        chk($sformatf("m%0d_held", i), 32'(d_hld[i]),
            32'(!rst && m_held[i]));
        chk($sformatf("m%0d_multi", i), 32'(d_mer[i]),
            32'(!rst && e_idle && ($countones(m_s[i]) > 1)));
        if (d_vld[i] === 1'b1) begin
          pcnt[i]++;
          pcyc[i] = cyc;
          pval[i] = d_oh[i];
        end
        if (phld[i] === 1'b1 && d_hld[i] === 1'b0) fcyc[i] = cyc;
        phld[i] = d_hld[i];
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] gen(input int kind, input logic [9:0] oh);
    logic [9:0] v;
    v = '0;
    if (kind <= 2) begin
      v = '0;
    end else if (kind <= 7) begin
      v = oh;
    end else begin
      v = 10'($urandom) | oh;
      v[($urandom_range(0, 9))] = 1'b1;
    end
    return v;
  endfunction

  initial begin
    int n;
    int p;
    rst = 1'b1;
    kb0.keys_raw = '0;
    kb1.keys_raw = '0;
    tick(3);
    chk("rst_valid", 32'(kb0.key_valid), 0);
    chk("rst_onehot", 32'(kb0.key_onehot), 0);
    chk("rst_held", 32'(kb0.key_held), 0);
    rst = 1'b0;
    tick(2);

    // clean press, then release
    n = cyc; p = pcnt[0];
    kb0.keys_raw = 10'h008;
    tick(20);
    chk("press_count", 32'(pcnt[0] - p), 1);
    chk("press_latency", 32'(pcyc[0] - n), 6);
    chk("press_value", 32'(pval[0]), 32'h008);
    chk("press_held", 32'(kb0.key_held), 1);
    n = cyc;
    kb0.keys_raw = '0;
    tick(10);
    chk("release_latency", 32'(fcyc[0] - n), 6);

    // bounce
    n = cyc; p = pcnt[0];
    for (int k = 0; k < 6; k++) begin
      kb0.keys_raw = (k % 2 == 0) ? 10'h010 : 10'h000;
      tick(1);
    end
    kb0.keys_raw = 10'h010;
    tick(12);
    chk("bounce_count", 32'(pcnt[0] - p), 1);
    chk("bounce_latency", 32'(pcyc[0] - n), 12);
    kb0.keys_raw = '0;
    tick(10);

    // multi-key
    p = pcnt[0];
    kb0.keys_raw = 10'h003;
    tick(2);
    chk("multi_set", 32'(kb0.multi_err), 1);
    tick(6);
    chk("multi_nopulse", 32'(pcnt[0] - p), 0);
    n = cyc;
    kb0.keys_raw = 10'h002;
    tick(2);
    chk("multi_clear", 32'(kb0.multi_err), 0);
    tick(8);
    chk("multi_count", 32'(pcnt[0] - p), 1);
    chk("multi_latency", 32'(pcyc[0] - n), 6);
    chk("multi_value", 32'(pval[0]), 32'h002);
    kb0.keys_raw = '0;
    tick(10);

    // roll-over and short release
    kb0.keys_raw = 10'h001;
    tick(10);
    p = pcnt[0];
    kb0.keys_raw = 10'h200;
    tick(6);
    kb0.keys_raw = '0;
    tick(3);
    kb0.keys_raw = 10'h200;
    tick(6);
    chk("roll_held", 32'(kb0.key_held), 1);
    chk("roll_nopulse", 32'(pcnt[0] - p), 0);
    kb0.keys_raw = '0;
    tick(8);
    chk("roll_release", 32'(kb0.key_held), 0);
    n = cyc; p = pcnt[0];
    kb0.keys_raw = 10'h200;
    tick(10);
    chk("roll_repress", 32'(pcnt[0] - p), 1);
    chk("roll_value", 32'(pval[0]), 32'h200);
    chk("roll_latency", 32'(pcyc[0] - n), 6);
    kb0.keys_raw = '0;
    tick(10);

    // reset mid-debounce
    n = cyc; p = pcnt[0];
    kb0.keys_raw = 10'h020;
    tick(3);
    rst = 1'b1;
    chk("rstmid_valid", 32'(kb0.key_valid), 0);
    chk("rstmid_held", 32'(kb0.key_held), 0);
    tick(1);
    chk("rstmid_onehot", 32'(kb0.key_onehot), 0);
    chk("rstmid_multi", 32'(kb0.multi_err), 0);
    chk("rstmid_nopulse", 32'(pcnt[0] - p), 0);
    rst = 1'b0;
    tick(10);
    chk("rstmid_count", 32'(pcnt[0] - p), 1);
    chk("rstmid_latency", 32'(pcyc[0] - n), 10);
    kb0.keys_raw = '0;
    tick(10);

    // single-sample debounce
    n = cyc; p = pcnt[1];
    kb1.keys_raw = 10'h100;
    tick(6);
    chk("d1_count", 32'(pcnt[1] - p), 1);
    chk("d1_latency", 32'(pcyc[1] - n), 3);
    chk("d1_value", 32'(pval[1]), 32'h100);
    n = cyc;
    kb1.keys_raw = '0;
    tick(6);
    chk("d1_release", 32'(fcyc[1] - n), 3);

    // random traffic on both instances
    for (int seg = 0; seg < 400; seg++) begin
      int k0;
      int k1;
      int len;
      logic [9:0] o0;
      logic [9:0] o1;
      k0 = $urandom_range(0, 9);
      k1 = $urandom_range(0, 9);
      o0 = 10'd1 << $urandom_range(0, 9);
      o1 = 10'd1 << $urandom_range(0, 9);
      len = $urandom_range(1, 10);
      rst = ($urandom_range(0, 39) == 0);
      for (int t = 0; t < len; t++) begin
        kb0.keys_raw = (k0 == 9 && t % 2 == 1) ? 10'd0 : gen(k0, o0);
        kb1.keys_raw = (k1 == 9 && t % 2 == 1) ? 10'd0 : gen(k1, o1);
        tick(1);
        rst = 1'b0;
      end
    end
    rst = 1'b0;
    kb0.keys_raw = '0;
    kb1.keys_raw = '0;
    tick(12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
